// File: rtl/xcfi_check_sequencer.sv
// Counts RVFI retirements and flags, combinationally, the CHECK_DEPTH-th counted one.
// Optional macro XCFI_COUNT_TRAPS_EN: trapping retirements are counted and selectable.
module xcfi_check_sequencer #(
  parameter int  NRET        = 1,
  parameter int  CHECK_DEPTH = 4,
  parameter int  TIMEOUT     = 32,
  localparam int CW          = (NRET > 1) ? $clog2(NRET) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NRET-1:0] rvfi_valid,
  input  logic [NRET-1:0] rvfi_trap,
  input  logic [NRET-1:0] rvfi_halt,
  output logic            check,
  output logic [CW-1:0]   check_channel,
  output logic [15:0]     retire_count,
  output logic            done,
  output logic            timed_out,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DONE,
    S_TIMEOUT,
    S_HALT
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [NRET-1:0] cm;
  logic [16:0]     n;
  logic            found;
  logic [CW-1:0]   hit_chan;
  logic            hit;
  logic            halt_req;
  logic [7:0]      idle_cnt;
  logic [7:0]      idle_next;
  logic [15:0]     count_next;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [16:0] b);
    logic [16:0] s;
    s = {1'b0, a} + b;
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

`ifdef XCFI_COUNT_TRAPS_EN
  logic unused_trap;
  assign unused_trap = ^rvfi_trap;
  assign cm = rvfi_valid;
`else
  assign cm = rvfi_valid & ~rvfi_trap;
`endif

  // Popcount plus the lowest channel whose running rank lands exactly on the target.
  always_comb begin
    n        = '0;
    found    = 1'b0;
    hit_chan = '0;
    for (int i = 0; i < NRET; i++) begin
      if (cm[i]) begin
        n = n + 17'd1;
        if (!found && (({1'b0, retire_count} + n) == 17'(CHECK_DEPTH))) begin
          found    = 1'b1;
          hit_chan = CW'(i);
        end
      end
    end
  end

  assign hit      = (({1'b0, retire_count} + n) >= 17'(CHECK_DEPTH));
  assign halt_req = |(rvfi_valid & rvfi_halt);

  always_comb begin
    state_next    = state;
    count_next    = retire_count;
    idle_next     = idle_cnt;
    check         = 1'b0;
    check_channel = '0;
    case (state)
      S_IDLE: state_next = S_COUNT;
      S_COUNT: begin
        count_next = sat_add16(retire_count, n);
        idle_next  = (n != 17'd0) ? 8'd0 : (idle_cnt + 8'd1);
        if (hit) begin
          check         = reset;
          check_channel = reset ? hit_chan : '0;
          state_next    = S_DONE;
        end else if (halt_req) begin
          state_next = S_HALT;
        end else if ((n == 17'd0) && ((idle_cnt + 8'd1) == 8'(TIMEOUT))) begin
          state_next = S_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Terminal flags are decoded from the next state so they rise one cycle after the trigger.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= S_IDLE;
      retire_count <= '0;
      idle_cnt     <= '0;
      done         <= 1'b0;
      timed_out    <= 1'b0;
      halted       <= 1'b0;
    end else begin
      state        <= state_next;
      retire_count <= count_next;
      idle_cnt     <= idle_next;
      done         <= (state_next == S_DONE);
      timed_out    <= (state_next == S_TIMEOUT);
      halted       <= (state_next == S_HALT);
    end
  end

endmodule
